// File: rtl/gbf_load_sched_pkg.sv
// gbf_load_sched_pkg: FSM encoding, default global-buffer widths and the segment length clamp
package gbf_load_sched_pkg;
    localparam int GBF_WEI_AW  = 10;
    localparam int GBF_WEI_DW  = 64;
    localparam int GBF_FWEI_DW = 32;
    localparam int GBF_ACT_AW  = 12;
    localparam int GBF_ACT_DW  = 8;
    localparam int GBF_FACT_DW = 32;
    localparam int GBF_IN_DW   = 64;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WEI  = 3'd1;
    localparam logic [2:0] S_FWEI = 3'd2;
    localparam logic [2:0] S_ACT  = 3'd3;
    localparam logic [2:0] S_FACT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        WEI  = S_WEI,
        FWEI = S_FWEI,
        ACT  = S_ACT,
        FACT = S_FACT,
        DONE = S_DONE
    } state_t;

    function automatic logic [31:0] clamp_len(input logic [31:0] len, input int aw);
        return (len > (32'd1 << aw)) ? (32'd1 << aw) : len;
    endfunction
endpackage

// File: rtl/gbf_load_sched_if.sv
// gbf_load_sched_if: host word stream, load descriptor and the four buffer write ports
interface gbf_load_sched_if
    import gbf_load_sched_pkg::*;
#(
    parameter int WEI_AW  = GBF_WEI_AW,
    parameter int WEI_DW  = GBF_WEI_DW,
    parameter int FWEI_DW = GBF_FWEI_DW,
    parameter int ACT_AW  = GBF_ACT_AW,
    parameter int ACT_DW  = GBF_ACT_DW,
    parameter int FACT_DW = GBF_FACT_DW,
    parameter int IN_DW   = GBF_IN_DW
);
    logic                start;
    logic [WEI_AW:0]     cfg_len_wei, cfg_len_fwei;
    logic [ACT_AW:0]     cfg_len_act, cfg_len_fact;
    logic [WEI_AW-1:0]   cfg_base_wei, cfg_base_fwei;
    logic [ACT_AW-1:0]   cfg_base_act, cfg_base_fact;
    logic                in_valid, in_ready;
    logic [IN_DW-1:0]    in_data;
    logic                wei_en, fwei_en, act_en, fact_en;
    logic                wei_val, fwei_val, act_val, fact_val;
    logic [WEI_AW-1:0]   wei_addr, fwei_addr;
    logic [ACT_AW-1:0]   act_addr, fact_addr;
    logic [WEI_DW-1:0]   wei_dat;
    logic [FWEI_DW-1:0]  fwei_dat;
    logic [ACT_DW-1:0]   act_dat;
    logic [FACT_DW-1:0]  fact_dat;
    logic                busy, done;

    modport master (
        output start, cfg_len_wei, cfg_len_fwei, cfg_len_act, cfg_len_fact,
               cfg_base_wei, cfg_base_fwei, cfg_base_act, cfg_base_fact, in_valid, in_data,
        input  in_ready, wei_en, fwei_en, act_en, fact_en, wei_val, fwei_val, act_val, fact_val,
               wei_addr, fwei_addr, act_addr, fact_addr, wei_dat, fwei_dat, act_dat, fact_dat,
               busy, done
    );
    modport slave (
        input  start, cfg_len_wei, cfg_len_fwei, cfg_len_act, cfg_len_fact,
               cfg_base_wei, cfg_base_fwei, cfg_base_act, cfg_base_fact, in_valid, in_data,
        output in_ready, wei_en, fwei_en, act_en, fact_en, wei_val, fwei_val, act_val, fact_val,
               wei_addr, fwei_addr, act_addr, fact_addr, wei_dat, fwei_dat, act_dat, fact_dat,
               busy, done
    );
endinterface

// File: rtl/gbf_seg_cnt.sv
// gbf_seg_cnt: segment length down-counter with a wrapping write-address register
module gbf_seg_cnt #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW:0]   len,
    input  logic [AW-1:0] base,
    output logic [AW-1:0] addr,
    output logic          zero,
    output logic          last
);
    logic [AW:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            addr <= '0;
        end else if (load) begin
            cnt  <= len;
            addr <= base;
        end else if (step) begin
            cnt  <= cnt - 1'b1;
            addr <= addr + 1'b1;
        end
    end

    assign zero = cnt == '0;
    assign last = cnt == (AW+1)'(1);
endmodule

// File: rtl/gbf_load_sched.sv
// gbf_load_sched: steers a host word stream into the four input global-buffer write ports
module gbf_load_sched
    import gbf_load_sched_pkg::*;
#(
    parameter int WEI_AW  = GBF_WEI_AW,
    parameter int WEI_DW  = GBF_WEI_DW,
    parameter int FWEI_DW = GBF_FWEI_DW,
    parameter int ACT_AW  = GBF_ACT_AW,
    parameter int ACT_DW  = GBF_ACT_DW,
    parameter int FACT_DW = GBF_FACT_DW
) (
    input logic             clk,
    input logic             rst_n,
    gbf_load_sched_if.slave bus
);
    localparam int CAW = (WEI_AW > ACT_AW) ? WEI_AW : ACT_AW;

    state_t         state;
    logic [CAW:0]   len_fwei, len_act, len_fact, seg_len;
    logic [CAW-1:0] base_fwei, base_act, base_fact, seg_base, addr;
    logic           seg, beat, zero, last, load;

    assign seg          = state inside {WEI, FWEI, ACT, FACT};
    assign bus.in_ready = seg && !zero;
    assign bus.busy     = state != IDLE;
    assign beat         = bus.in_valid && bus.in_ready;
    // The counter is reloaded at start and whenever an exhausted segment hands over
    assign load         = (state == IDLE) ? bus.start : seg && zero;
    assign seg_len  = state == IDLE ? (CAW+1)'(clamp_len(32'(bus.cfg_len_wei), WEI_AW)) :
                      state == WEI  ? len_fwei : state == FWEI ? len_act :
                      state == ACT  ? len_fact : '0;
    assign seg_base = state == IDLE ? CAW'(bus.cfg_base_wei) :
                      state == WEI  ? base_fwei : state == FWEI ? base_act :
                      state == ACT  ? base_fact : '0;

    gbf_seg_cnt #(.AW(CAW)) u_cnt (
        .clk(clk), .rst_n(rst_n), .load(load), .step(beat), .len(seg_len), .base(seg_base),
        .addr(addr), .zero(zero), .last(last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            {len_fwei, len_act, len_fact}    <= '0;
            {base_fwei, base_act, base_fact} <= '0;
            {bus.wei_en, bus.fwei_en, bus.act_en, bus.fact_en}     <= '0;
            {bus.wei_val, bus.fwei_val, bus.act_val, bus.fact_val} <= '0;
            {bus.wei_addr, bus.fwei_addr, bus.act_addr, bus.fact_addr} <= '0;
            {bus.wei_dat, bus.fwei_dat, bus.act_dat, bus.fact_dat}     <= '0;
            bus.done <= 1'b0;
        end else begin
            bus.wei_en  <= beat && state == WEI;
            bus.fwei_en <= beat && state == FWEI;
            bus.act_en  <= beat && state == ACT;
            bus.fact_en <= beat && state == FACT;
            bus.done    <= state == FACT && zero;
            if (beat && state == WEI) begin
                bus.wei_addr <= addr[WEI_AW-1:0];
                bus.wei_dat  <= bus.in_data[WEI_DW-1:0];
                if (last) bus.wei_val <= 1'b1;
            end
            if (beat && state == FWEI) begin
                bus.fwei_addr <= addr[WEI_AW-1:0];
                bus.fwei_dat  <= bus.in_data[FWEI_DW-1:0];
                if (last) bus.fwei_val <= 1'b1;
            end
            if (beat && state == ACT) begin
                bus.act_addr <= addr[ACT_AW-1:0];
                bus.act_dat  <= bus.in_data[ACT_DW-1:0];
                if (last) bus.act_val <= 1'b1;
            end
            if (beat && state == FACT) begin
                bus.fact_addr <= addr[ACT_AW-1:0];
                bus.fact_dat  <= bus.in_data[FACT_DW-1:0];
                if (last) bus.fact_val <= 1'b1;
            end
            // An empty segment marks its buffer valid as soon as it is entered
            case (state)
                IDLE: if (bus.start) begin
                    state     <= WEI;
                    len_fwei  <= (CAW+1)'(clamp_len(32'(bus.cfg_len_fwei), WEI_AW));
                    len_act   <= (CAW+1)'(clamp_len(32'(bus.cfg_len_act), ACT_AW));
                    len_fact  <= (CAW+1)'(clamp_len(32'(bus.cfg_len_fact), ACT_AW));
                    base_fwei <= CAW'(bus.cfg_base_fwei);
                    base_act  <= CAW'(bus.cfg_base_act);
                    base_fact <= CAW'(bus.cfg_base_fact);
                    {bus.fact_val, bus.act_val, bus.fwei_val} <= '0;
                    bus.wei_val <= seg_len == '0;
                end
                WEI:  if (zero) begin
                    state        <= FWEI;
                    bus.fwei_val <= len_fwei == '0;
                end
                FWEI: if (zero) begin
                    state       <= ACT;
                    bus.act_val <= len_act == '0;
                end
                ACT:  if (zero) begin
                    state        <= FACT;
                    bus.fact_val <= len_fact == '0;
                end
                FACT: if (zero) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gbf_load_sched.sv
// tb_gbf_load_sched: directed load sequences checked against a scoreboard of expected buffer writes
module tb_gbf_load_sched;
    import gbf_load_sched_pkg::*;

    typedef struct {
        int          b;
        logic [63:0] addr;
        logic [63:0] dat;
        bit          last;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0, s_cyc = 0, checks = 0, errors = 0;
    int   rise [4];
    logic ready_frise = 1'bx;
    sb_t  exp_seq[$], sb[$];

    gbf_load_sched_if bus ();
    gbf_load_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [3:0] ens();
        return {bus.fact_en, bus.act_en, bus.fwei_en, bus.wei_en};
    endfunction

    function automatic logic [3:0] vals();
        return {bus.fact_val, bus.act_val, bus.fwei_val, bus.wei_val};
    endfunction

    function automatic logic [63:0] addr_of(input int b);
        return b == 0 ? 64'(bus.wei_addr) : b == 1 ? 64'(bus.fwei_addr) :
               b == 2 ? 64'(bus.act_addr) : 64'(bus.fact_addr);
    endfunction

    function automatic logic [63:0] dat_of(input int b);
        return b == 0 ? 64'(bus.wei_dat) : b == 1 ? 64'(bus.fwei_dat) :
               b == 2 ? 64'(bus.act_dat) : 64'(bus.fact_dat);
    endfunction

    function automatic logic [63:0] mask(input int b);
        return b == 0 ? 64'hffff_ffff_ffff_ffff : b == 2 ? 64'hff : 64'hffff_ffff;
    endfunction

    function automatic logic anyout();
        return |{ens(), vals(), bus.in_ready, bus.busy, bus.done,
                 bus.wei_addr, bus.fwei_addr, bus.act_addr, bus.fact_addr,
                 bus.wei_dat, bus.fwei_dat, bus.act_dat, bus.fact_dat};
    endfunction

    task automatic do_start(input int l0, l1, l2, l3, input int b0, b1, b2, b3);
        int  len [4];
        int  base [4];
        sb_t e;
        len  = '{l0, l1, l2, l3};
        base = '{b0, b1, b2, b3};
        bus.cfg_len_wei   = l0[10:0];
        bus.cfg_len_fwei  = l1[10:0];
        bus.cfg_len_act   = l2[12:0];
        bus.cfg_len_fact  = l3[12:0];
        bus.cfg_base_wei  = b0[9:0];
        bus.cfg_base_fwei = b1[9:0];
        bus.cfg_base_act  = b2[11:0];
        bus.cfg_base_fact = b3[11:0];
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        s_cyc = cyc;
        exp_seq.delete();
        sb.delete();
        rise = '{-1, -1, -1, -1};
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < len[b]; i++) begin
                e.b    = b;
                e.addr = 64'((base[b] + i) % (b < 2 ? 1024 : 4096));
                e.dat  = '0;
                e.last = i == len[b] - 1;
                exp_seq.push_back(e);
            end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_val_clr", 64'(vals()), 0);
        chk("start_busy", bus.busy, 1);
        chk("start_ready", bus.in_ready, l0 != 0);
    endtask

    task automatic run(input bit toggle, input int poke, input int want_done);
        sb_t        e;
        bit         hs;
        bit         seen = 0;
        logic [3:0] v;
        logic [3:0] pv = vals();
        for (int n = 0; n < 200 && !seen; n++) begin
            bus.in_valid = toggle ? n[0] : 1'b1;
            bus.in_data  = {$urandom, $urandom};
            bus.start    = (cyc - s_cyc) == poke;
            if (bus.start) bus.cfg_len_act = 13'd7;
            hs = bus.in_valid && bus.in_ready;
            if (hs) begin
                checks++;
                assert (exp_seq.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_beat: observed ready at cycle %0d expected no words left to accept", cyc - s_cyc);
                end
                if (exp_seq.size() != 0) begin
                    e = exp_seq.pop_front();
                    e.dat = bus.in_data & mask(e.b);
                    sb.push_back(e);
                end
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            v = vals();
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_en", 64'(ens()), 64'(1) << e.b);
                chk("wr_addr", addr_of(e.b), e.addr);
                chk("wr_dat", dat_of(e.b), e.dat);
                chk("val_at_wr", v[e.b], e.last);
            end else
                chk("no_wr", 64'(ens()), 0);
            for (int b = 0; b < 4; b++)
                if (v[b] && !pv[b]) rise[b] = cyc;
            if (v[1] && !pv[1]) ready_frise = bus.in_ready;
            pv = v;
            if (bus.done) begin
                seen = 1;
                if (want_done >= 0) chk("done_cyc", cyc - s_cyc, want_done);
            end
        end
        bus.in_valid = 1'b0;
        chk("done_seen", seen, 1);
        chk("all_beats", exp_seq.size() + sb.size(), 0);
        @(posedge clk); #1;
        chk("done_pulse", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("val_hold", 64'(vals()), 64'hf);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        {bus.cfg_len_wei, bus.cfg_len_fwei, bus.cfg_len_act, bus.cfg_len_fact} = '0;
        {bus.cfg_base_wei, bus.cfg_base_fwei, bus.cfg_base_act, bus.cfg_base_fact} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", anyout(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", bus.in_ready, 0);

        do_start(3, 2, 4, 1, 0, 0, 0, 0);
        run(1'b0, -1, 15);

        do_start(3, 2, 4, 1, 0, 0, 0, 0);
        run(1'b1, -1, -1);

        do_start(2, 0, 2, 2, 0, 0, 0, 0);
        run(1'b0, -1, 11);
        chk("skip_gap", rise[1] - rise[0], 1);
        chk("skip_ready", ready_frise, 0);

        do_start(1, 1, 4, 1, 0, 0, 4094, 0);
        run(1'b0, -1, 12);

        do_start(3, 2, 4, 1, 0, 0, 0, 0);
        run(1'b0, 9, 15);

        do_start(5, 1, 1, 1, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h1234_5678_9abc_def0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst", anyout(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_rst_ready", bus.in_ready, 0);
            chk("post_rst_busy", bus.busy, 0);
            chk("post_rst_wr", 64'(ens()), 0);
        end
        bus.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
